// File: rtl/compare_searcher.sv
// Binary-search controller that questions a combinational magnitude comparator
// through guess_o and narrows its bounds from the one-hot gt/eq/lt reply.
//
// state | meaning
// IDLE  | waiting for start, all outputs at reset values
// GUESS | guess_o presented, comparator flags sampled each edge
// DONE  | hidden value located, found_o valid, outputs held
// ERR   | responder reply inconsistent, outputs held
module compare_searcher #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             gt_i,
  input  logic             eq_i,
  input  logic             lt_i,
  output logic [WIDTH-1:0] guess_o,
  output logic             guess_valid_o,
  output logic             done_o,
  output logic             err_o,
  output logic [WIDTH-1:0] found_o,
  output logic [WIDTH:0]   steps_o
);

  typedef enum logic [1:0] {IDLE, GUESS, DONE, ERR} state_t;

  localparam logic [WIDTH-1:0] VAL_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] VAL_MAX  = {WIDTH{1'b1}};
  localparam logic [WIDTH:0]   STEP_ONE = (WIDTH+1)'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] guess_q, guess_d;
  logic [WIDTH-1:0] found_q, found_d;
  logic [WIDTH:0]   steps_q, steps_d;

  // Sum is widened by one bit so the midpoint of the full range cannot wrap.
  function automatic logic [WIDTH-1:0] mid(input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b);
    logic [WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[WIDTH:1];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lo_q    <= '0;
      hi_q    <= '0;
      guess_q <= '0;
      found_q <= '0;
      steps_q <= '0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      guess_q <= guess_d;
      found_q <= found_d;
      steps_q <= steps_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    guess_d = guess_q;
    found_d = found_q;
    steps_d = steps_q;

    case (state_q)
      GUESS: begin
        case ({gt_i, eq_i, lt_i})
          3'b010: begin
            found_d = guess_q;
            state_d = DONE;
          end
          3'b100: begin
            if (guess_q == hi_q) begin
              state_d = ERR;
            end else begin
              lo_d    = guess_q + VAL_ONE;
              guess_d = mid(guess_q + VAL_ONE, hi_q);
              steps_d = steps_q + STEP_ONE;
            end
          end
          3'b001: begin
            if (guess_q == lo_q) begin
              state_d = ERR;
            end else begin
              hi_d    = guess_q - VAL_ONE;
              guess_d = mid(lo_q, guess_q - VAL_ONE);
              steps_d = steps_q + STEP_ONE;
            end
          end
          default: state_d = ERR;
        endcase
      end
      default: begin
        // IDLE, DONE and ERR all restart identically; found is kept until overwritten.
        if (start_i) begin
          lo_d    = '0;
          hi_d    = VAL_MAX;
          guess_d = mid('0, VAL_MAX);
          steps_d = STEP_ONE;
          state_d = GUESS;
        end
      end
    endcase
  end

  assign guess_o       = guess_q;
  assign found_o       = found_q;
  assign steps_o       = steps_q;
  assign guess_valid_o = (state_q == GUESS);
  assign done_o        = (state_q == DONE);
  assign err_o         = (state_q == ERR);

endmodule
